// File: rtl/vga_color_out.sv
// vga_color_out: final VGA output stage.
// Looks up the scaler's 4-bit colour index in a 16-entry programmable
// palette, applies blanking and optional odd-line scanline dimming, and
// delays hsync/vsync/active by the same two register stages so every
// output stays cycle-aligned.
module vga_color_out (
    input  logic        clk_dot4x,
    input  logic        rst,
    input  logic [3:0]  pixel_color4,
    input  logic        hs_in,
    input  logic        vs_in,
    input  logic        active_in,
    input  logic        line_odd,
    input  logic        scanline_en,
    input  logic        pal_we,
    input  logic [3:0]  pal_addr,
    input  logic [17:0] pal_data,
    output logic [5:0]  red,
    output logic [5:0]  green,
    output logic [5:0]  blue,
    output logic        hsync,
    output logic        vsync,
    output logic        active_out
);

    // Power-on C64 palette, packed {R[17:12], G[11:6], B[5:0]}.
    function automatic logic [17:0] default_color(input logic [3:0] idx);
        logic [17:0] c;
        case (idx)
            4'd0:    c = {6'h00, 6'h00, 6'h00};
            4'd1:    c = {6'h3F, 6'h3F, 6'h3F};
            4'd2:    c = {6'h1A, 6'h0D, 6'h0A};
            4'd3:    c = {6'h1C, 6'h29, 6'h2C};
            4'd4:    c = {6'h1B, 6'h0F, 6'h21};
            4'd5:    c = {6'h16, 6'h23, 6'h10};
            4'd6:    c = {6'h0D, 6'h0A, 6'h1E};
            4'd7:    c = {6'h2E, 6'h31, 6'h1B};
            4'd8:    c = {6'h1B, 6'h13, 6'h09};
            4'd9:    c = {6'h10, 6'h0E, 6'h00};
            4'd10:   c = {6'h26, 6'h19, 6'h16};
            4'd11:   c = {6'h11, 6'h11, 6'h11};
            4'd12:   c = {6'h1B, 6'h1B, 6'h1B};
            4'd13:   c = {6'h26, 6'h34, 6'h21};
            4'd14:   c = {6'h1B, 6'h17, 6'h2D};
            default: c = {6'h25, 6'h25, 6'h25};
        endcase
        return c;
    endfunction

    // Palette storage
    logic [17:0] palette_q [16];
    logic [17:0] palette_d [16];

    // Stage 1 registers
    logic [17:0] s1_rgb_q,    s1_rgb_d;
    logic        s1_active_q, s1_active_d;
    logic        s1_dim_q,    s1_dim_d;
    logic        s1_hs_q,     s1_hs_d;
    logic        s1_vs_q,     s1_vs_d;

    // Stage 2 (output) registers
    logic [17:0] rgb_q,       rgb_d;
    logic        hsync_q,     hsync_d;
    logic        vsync_q,     vsync_d;
    logic        active_q,    active_d;

    // Palette next state: one entry may be overwritten per cycle.
    always_comb begin
        // NOTE: copy the current contents first so every element has a value on every path; no latch.
        palette_d = palette_q;
        if (pal_we) begin
            palette_d[pal_addr] = pal_data;
        end
    end

    // Palette register file, reloaded with the default table on reset.
    always_ff @(posedge clk_dot4x) begin
        if (rst) begin
            // NOTE: this memory is deliberately reset; the defaults must be restored by rst, so it maps to flops, not RAM.
            for (int i = 0; i < 16; i++) begin
                palette_q[i] <= default_color(4'(i));
            end
        end else begin
            palette_q <= palette_d;
        end
    end

    // Stage 1 capture: palette lookup reads the pre-write contents,
    // which gives read-before-write on a same-edge update.
    always_comb begin
        s1_rgb_d    = palette_q[pixel_color4];
        s1_active_d = active_in;
        s1_dim_d    = scanline_en & line_odd;
        s1_hs_d     = hs_in;
        s1_vs_d     = vs_in;
    end

    // Stage 2 compute: blank outside the active region, halve on dimmed lines.
    always_comb begin
        rgb_d    = s1_rgb_q;
        hsync_d  = s1_hs_q;
        vsync_d  = s1_vs_q;
        active_d = s1_active_q;
        if (!s1_active_q) begin
            rgb_d = 18'h0;
        end else if (s1_dim_q) begin
            rgb_d = {1'b0, s1_rgb_q[17:13], 1'b0, s1_rgb_q[11:7], 1'b0, s1_rgb_q[5:1]};
        end
    end

    // Pipeline registers; reset to blanked RGB with syncs inactive (high).
    always_ff @(posedge clk_dot4x) begin
        if (rst) begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            s1_rgb_q    <= 18'h0;
            s1_active_q <= 1'b0;
            s1_dim_q    <= 1'b0;
            s1_hs_q     <= 1'b1;
            s1_vs_q     <= 1'b1;
            rgb_q       <= 18'h0;
            hsync_q     <= 1'b1;
            vsync_q     <= 1'b1;
            active_q    <= 1'b0;
        end else begin
            s1_rgb_q    <= s1_rgb_d;
            s1_active_q <= s1_active_d;
            s1_dim_q    <= s1_dim_d;
            s1_hs_q     <= s1_hs_d;
            s1_vs_q     <= s1_vs_d;
            rgb_q       <= rgb_d;
            hsync_q     <= hsync_d;
            vsync_q     <= vsync_d;
            active_q    <= active_d;
        end
    end

    assign red        = rgb_q[17:12];
    assign green      = rgb_q[11:6];
    assign blue       = rgb_q[5:0];
    assign hsync      = hsync_q;
    assign vsync      = vsync_q;
    assign active_out = active_q;

endmodule

// File: tb/tb_vga_color_out.sv
// tb_vga_color_out: directed vectors with hand-computed expected colours.
// Each driven cycle pushes its expected output word into a queue; the
// monitor pops one word per cycle, two cycles after it was pushed.
module tb_vga_color_out;

    logic        clk_dot4x = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  pixel_color4 = 4'd0;
    logic        hs_in = 1'b1;
    logic        vs_in = 1'b1;
    logic        active_in = 1'b0;
    logic        line_odd = 1'b0;
    logic        scanline_en = 1'b0;
    logic        pal_we = 1'b0;
    logic [3:0]  pal_addr = 4'd0;
    logic [17:0] pal_data = 18'h0;
    logic [5:0]  red, green, blue;
    logic        hsync, vsync, active_out;

    vga_color_out dut (
        .clk_dot4x    (clk_dot4x),
        .rst          (rst),
        .pixel_color4 (pixel_color4),
        .hs_in        (hs_in),
        .vs_in        (vs_in),
        .active_in    (active_in),
        .line_odd     (line_odd),
        .scanline_en  (scanline_en),
        .pal_we       (pal_we),
        .pal_addr     (pal_addr),
        .pal_data     (pal_data),
        .red          (red),
        .green        (green),
        .blue         (blue),
        .hsync        (hsync),
        .vsync        (vsync),
        .active_out   (active_out)
    );

    always #5 clk_dot4x = ~clk_dot4x;

    // Expected word: {R, G, B, hsync, vsync, active_out}
    localparam logic [20:0] RESET_WORD = {18'h0, 1'b1, 1'b1, 1'b0};

    logic [20:0] exp_q [$];
    string       lbl_q [$];
    int          n_checks = 0;
    int          n_pass   = 0;

    // Default table as listed for the block, {R,G,B}.
    logic [17:0] def_tab [16] = '{
        {6'h00, 6'h00, 6'h00}, {6'h3F, 6'h3F, 6'h3F}, {6'h1A, 6'h0D, 6'h0A}, {6'h1C, 6'h29, 6'h2C},
        {6'h1B, 6'h0F, 6'h21}, {6'h16, 6'h23, 6'h10}, {6'h0D, 6'h0A, 6'h1E}, {6'h2E, 6'h31, 6'h1B},
        {6'h1B, 6'h13, 6'h09}, {6'h10, 6'h0E, 6'h00}, {6'h26, 6'h19, 6'h16}, {6'h11, 6'h11, 6'h11},
        {6'h1B, 6'h1B, 6'h1B}, {6'h26, 6'h34, 6'h21}, {6'h1B, 6'h17, 6'h2D}, {6'h25, 6'h25, 6'h25}
    };

    task automatic check(input string name, input logic [20:0] act, input logic [20:0] expv);
        n_checks++;
        if (act === expv) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got rgb=%h hs/vs/act=%b required rgb=%h hs/vs/act=%b",
                     name, act[20:3], act[2:0], expv[20:3], expv[2:0]);
        end
    endtask

    // Issue one cycle of stimulus (inputs already set, we are at a negedge).
    // A reset cycle also blanks the word still in flight from the previous cycle.
    task automatic step(input logic [17:0] exp_rgb, input string lbl);
        if (rst) begin
            if (exp_q.size() > 0) exp_q[exp_q.size() - 1] = RESET_WORD;
            exp_q.push_back(RESET_WORD);
        end else begin
            exp_q.push_back({exp_rgb, hs_in, vs_in, active_in});
        end
        lbl_q.push_back(lbl);
        @(negedge clk_dot4x);
        pal_we = 1'b0;
        rst    = 1'b0;
    endtask

    task automatic write_pal(input logic [3:0] a, input logic [17:0] d);
        pal_we   = 1'b1;
        pal_addr = a;
        pal_data = d;
    endtask

    // Monitor: the word for the vector sampled at edge N is compared after edge N+1.
    initial begin
        logic [20:0] e;
        string       l;
        forever begin
            @(posedge clk_dot4x);
            #1;
            if (exp_q.size() >= 2) begin
                e = exp_q.pop_front();
                l = lbl_q.pop_front();
                check(l, {red, green, blue, hsync, vsync, active_out}, e);
            end
        end
    end

    initial begin
        @(negedge clk_dot4x);
        // Reset held three cycles.
        for (int i = 0; i < 3; i++) begin
            rst = 1'b1;
            step(18'h0, "reset");
        end

        // Default palette, each index held two cycles.
        active_in = 1'b1;
        for (int i = 0; i < 16; i++) begin
            pixel_color4 = 4'(i);
            step(def_tab[i], $sformatf("default_idx%0d_a", i));
            step(def_tab[i], $sformatf("default_idx%0d_b", i));
        end

        // Blanking: active toggles 1 -> 0 while showing white.
        pixel_color4 = 4'd1;
        step({6'h3F, 6'h3F, 6'h3F}, "white_active");
        step({6'h3F, 6'h3F, 6'h3F}, "white_active");
        active_in = 1'b0;
        step(18'h0, "white_blanked");
        step(18'h0, "white_blanked");
        active_in = 1'b1;

        // Sync pulses: 32 cycles low, aligned with RGB.
        hs_in = 1'b0;
        vs_in = 1'b0;
        for (int i = 0; i < 32; i++) step({6'h3F, 6'h3F, 6'h3F}, "sync_low");
        hs_in = 1'b1;
        vs_in = 1'b1;
        step({6'h3F, 6'h3F, 6'h3F}, "sync_high");
        hs_in = 1'b0;
        step({6'h3F, 6'h3F, 6'h3F}, "hs_only_low");
        hs_in = 1'b1;
        step({6'h3F, 6'h3F, 6'h3F}, "sync_high");

        // Scanline dimming.
        scanline_en = 1'b1;
        line_odd    = 1'b1;
        step({6'h1F, 6'h1F, 6'h1F}, "dim_white");
        step({6'h1F, 6'h1F, 6'h1F}, "dim_white");
        line_odd = 1'b0;
        step({6'h3F, 6'h3F, 6'h3F}, "even_line_white");
        line_odd     = 1'b1;
        pixel_color4 = 4'd13;
        step({6'h13, 6'h1A, 6'h10}, "dim_idx13");
        step({6'h13, 6'h1A, 6'h10}, "dim_idx13");
        active_in = 1'b0;
        step(18'h0, "dim_blanked");
        active_in   = 1'b1;
        scanline_en = 1'b0;
        step({6'h26, 6'h34, 6'h21}, "odd_no_scanline_idx13");
        line_odd = 1'b0;

        // Read-before-write on entry 5.
        pixel_color4 = 4'd5;
        write_pal(4'd5, 18'h3F000);
        step({6'h16, 6'h23, 6'h10}, "rbw_old_value");
        step({6'h3F, 6'h00, 6'h00}, "rbw_new_value");
        step({6'h3F, 6'h00, 6'h00}, "rbw_new_value");

        // Back-to-back writes to entries 8 and 9.
        pixel_color4 = 4'd0;
        write_pal(4'd8, 18'h2A5C3);
        step(18'h0, "b2b_write8");
        write_pal(4'd9, 18'h0ABCD);
        step(18'h0, "b2b_write9");
        pixel_color4 = 4'd8;
        step(18'h2A5C3, "b2b_read8");
        pixel_color4 = 4'd9;
        step(18'h0ABCD, "b2b_read9");

        // Write entry 3, see it, then reset mid-stream (with a write to 4 in the reset cycle).
        pixel_color4 = 4'd0;
        write_pal(4'd3, 18'h00FFF);
        step(18'h0, "write3");
        pixel_color4 = 4'd3;
        step({6'h00, 6'h3F, 6'h3F}, "read3_written");
        step({6'h00, 6'h3F, 6'h3F}, "read3_written");
        rst = 1'b1;
        write_pal(4'd4, 18'h3FFFF);
        step(18'h0, "midstream_reset");
        step({6'h1C, 6'h29, 6'h2C}, "read3_after_reset");
        step({6'h1C, 6'h29, 6'h2C}, "read3_after_reset");
        pixel_color4 = 4'd4;
        step({6'h1B, 6'h0F, 6'h21}, "read4_reset_beats_write");
        pixel_color4 = 4'd5;
        step({6'h16, 6'h23, 6'h10}, "read5_write_lost");
        pixel_color4 = 4'd8;
        step({6'h1B, 6'h13, 6'h09}, "read8_write_lost");

        // Trailing idle cycles drain the pipeline.
        active_in = 1'b0;
        for (int i = 0; i < 3; i++) step(18'h0, "idle");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
